accum_datapath: RTL and testbench
=================================

Name: accum_datapath

Overview:
- Datapath for the 8-bit accumulator CPU. It is driven by the control FSM, which sends IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub and Halt.
- It returns ir, Aeq0 and Apos to the FSM, and it owns IR, PC, A and the unified program/data RAM.
- It executes the LOAD/STORE/ADD/SUB/INPUT/JZ/JPOS/HALT instruction set using one 1-word-per-cycle synchronous-read memory.
- A side program-load port lets the bench or top level preload the RAM.

Parameters:
- ADDR_W, 5, address width. Memory depth is 2**ADDR_W and word width is W = ADDR_W+3.
- Instruction format is IR[W-1:W-3] = opcode and IR[ADDR_W-1:0] = operand address.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  master reset, asynchronous, active-high
- IRload  in  1  load IR from memory read data
- JMPmux  in  1  PC source: 1 = IR[ADDR_W-1:0], 0 = PC+1
- PCload  in  1  load PC
- Meminst  in  1  memory address select: 1 = IR[ADDR_W-1:0], 0 = PC
- MemWr  in  1  write A to memory at the selected address
- Asel  in  2  A source: 00 = add/sub result, 01 = Input, 10 = memory read data, 11 = zero
- Aload  in  1  load A
- Sub  in  1  adder mode: 1 = A - rdata, 0 = A + rdata
- Halt  in  1  halt strobe from the FSM
- Input  in  W  external data for INPUT
- prog_we  in  1  program-load write enable
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  W  program-load data
- ir  out  3  IR opcode field, IR[W-1:W-3]
- Aeq0  out  1  A == 0
- Apos  out  1  A > 0, signed: !A[W-1] && A != 0
- A_out  out  W  accumulator value
- PC_out  out  ADDR_W  program counter value
- halted  out  1  sticky halt status

Behaviour:
- Reset values: IR = 0, PC = 0, A = 0, rdata = 0, halted = 0. This gives ir = 000, Aeq0 = 1, Apos = 0. RAM contents are NOT reset.
- Address: addr = Meminst ? IR[ADDR_W-1:0] : PC. This is combinational from current registers.
- Read: the synchronous-read register is updated every clock with rdata <= mem[addr]. Data for the address presented in cycle n is usable in cycle n+1.
  - FSM START (Meminst=0) presents PC; FETCH consumes mem[PC].
  - DECODE (Meminst=1) presents the operand address; LOAD, ADD and SUB consume mem[operand].
- Read during write to the same address returns the old word (read-before-write).
- Write: if prog_we, then mem[prog_addr] <= prog_data. Else if MemWr, then mem[addr] <= A.
  - prog_we has priority; MemWr is ignored in that cycle.
  - The read path is unaffected by prog_we.
- IR: if IRload, IR <= rdata.
- PC: if PCload, PC <= JMPmux ? IR[ADDR_W-1:0] : PC+1, modulo 2**ADDR_W (0x1F+1 -> 0x00).
  - With PCload = 0, PC holds regardless of JMPmux.
- A: if Aload, A <= mux(Asel).
  - The add/sub result is A +/- rdata modulo 2**W. No carry or overflow flag.
- Flags Aeq0 and Apos are combinational from the registered A, so they are valid the cycle after the load.
- halted: set on any cycle with Halt = 1; it stays 1 until reset. It does not freeze the datapath.
- All register loads are independent. Simultaneous IRload, PCload and Aload in one cycle all take effect.
- Reset asserted mid-instruction: registers clear immediately (asynchronously) and RAM is kept. The first clock after deassertion behaves like START.

Test Plan:
- Reset: assert reset mid-run with A = 0x55, PC = 3 -> A = 0, PC = 0, ir = 000, Aeq0 = 1, Apos = 0, halted = 0; a RAM word written before reset still reads back.
- LOAD: preload mem[0] = 0x0A, mem[10] = 0x05. Drive START (all 0), FETCH (IRload, PCload), DECODE (Meminst), LOAD (Asel = 10, Aload) -> after FETCH: ir = 000 and PC = 1. After LOAD: A = 0x05, Apos = 1.
- ADD + STORE: preload mem[1] = 0x4B, mem[11] = 0x03, mem[2] = 0x2C, with A = 0x05. Run ADD (Aload) -> A = 0x08. Run STORE (Meminst, MemWr) -> mem[12] = 0x08, confirmed by a later LOAD 12.
- SUB wrap: A = 0x03, operand 0x05, SUB -> A = 0xFE, Aeq0 = 0, Apos = 0. Asel = 11 -> A = 0, Aeq0 = 1.
- Jumps and PC wrap:
  - IR = 0xBF with A = 0, JZ cycle (JMPmux = 1, PCload = Aeq0) -> PC = 0x1F.
  - Next FETCH -> PC = 0x00.
  - JPOS with A = 0x80 (PCload = Apos = 0) -> PC unchanged.
- INPUT, Halt and collision:
  - Asel = 01, Input = 0x7F, Aload -> A = 0x7F, Apos = 1.
  - Halt pulse -> halted = 1 and stays 1 over 10 cycles.
  - prog_we and MemWr together to different addresses -> only prog_addr is written.

Source files
------------

// File: rtl/accum_datapath.sv
// Datapath of the 8-bit accumulator CPU: IR, PC, A, sticky halt flag and the
// unified program/data RAM with a registered read port and a preload port.
module accum_datapath #(
  parameter int ADDR_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                IRload,
  input  logic                JMPmux,
  input  logic                PCload,
  input  logic                Meminst,
  input  logic                MemWr,
  input  logic [1:0]          Asel,
  input  logic                Aload,
  input  logic                Sub,
  input  logic                Halt,
  input  logic [ADDR_W+2:0]   Input,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [ADDR_W+2:0]   prog_data,
  output logic [2:0]          ir,
  output logic                Aeq0,
  output logic                Apos,
  output logic [ADDR_W+2:0]   A_out,
  output logic [ADDR_W-1:0]   PC_out,
  output logic                halted
);

  localparam int W     = ADDR_W + 3;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ASRC_ALU  = 2'b00,
    ASRC_IN   = 2'b01,
    ASRC_MEM  = 2'b10,
    ASRC_ZERO = 2'b11
  } asrc_e;

  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      rdata;
  logic              halted_q;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_next;
  logic [W-1:0]      alu;
  logic [W-1:0]      a_next;
  asrc_e             asrc;

  assign operand = ir_q[ADDR_W-1:0];
  assign addr    = Meminst ? operand : pc_q;
  assign pc_next = JMPmux ? operand : pc_q + ADDR_W'(1);
  assign alu     = Sub ? (a_q - rdata) : (a_q + rdata);
  assign asrc    = asrc_e'(Asel);

  always_comb begin
    a_next = '0;
    unique case (asrc)
      ASRC_ALU:  a_next = alu;
      ASRC_IN:   a_next = Input;
      ASRC_MEM:  a_next = rdata;
      ASRC_ZERO: a_next = '0;
      default:   a_next = '0;
    endcase
  end

  // RAM is not reset; the nonblocking write leaves the same-cycle read with the old word
  always_ff @(posedge clock) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    else if (MemWr)
      mem[addr] <= a_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q     <= '0;
      pc_q     <= '0;
      a_q      <= '0;
      rdata    <= '0;
      halted_q <= 1'b0;
    end else begin
      rdata <= mem[addr];
      if (IRload) ir_q     <= rdata;
      if (PCload) pc_q     <= pc_next;
      if (Aload)  a_q      <= a_next;
      if (Halt)   halted_q <= 1'b1;
    end
  end

  assign ir     = ir_q[W-1:W-3];
  assign Aeq0   = (a_q == '0);
  assign Apos   = !a_q[W-1] && (a_q != '0);
  assign A_out  = a_q;
  assign PC_out = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_accum_datapath.sv
// Directed bench for accum_datapath: drives FSM-like control sequences and
// compares registers, flags and RAM contents against hand-computed values.
module tb_accum_datapath;

  localparam int ADDR_W = 5;
  localparam int W      = ADDR_W + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              IRload = 1'b0, JMPmux = 1'b0, PCload = 1'b0, Meminst = 1'b0;
  logic              MemWr = 1'b0, Aload = 1'b0, Sub = 1'b0, Halt = 1'b0;
  logic [1:0]        Asel = 2'b00;
  logic [W-1:0]      Input = '0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [W-1:0]      prog_data = '0;
  logic [2:0]        ir;
  logic              Aeq0, Apos, halted;
  logic [W-1:0]      A_out;
  logic [ADDR_W-1:0] PC_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  accum_datapath #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel),
    .Aload(Aload), .Sub(Sub), .Halt(Halt), .Input(Input),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ir(ir), .Aeq0(Aeq0), .Apos(Apos), .A_out(A_out), .PC_out(PC_out),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls, sampled 1 time unit after the edge.
  task automatic step(input logic irl, input logic jmp, input logic pcl,
                      input logic mi, input logic mw, input logic [1:0] as,
                      input logic al, input logic sb, input logic hl);
    IRload = irl; JMPmux = jmp; PCload = pcl; Meminst = mi; MemWr = mw;
    Asel = as; Aload = al; Sub = sb; Halt = hl;
    @(posedge clock); #1;
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Asel = 2'b00; Aload = 0; Sub = 0; Halt = 0;
  endtask

  task automatic prog(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic idle();         step(0,0,0,0,0,2'b00,0,0,0); endtask
  task automatic fetch();        step(1,0,1,0,0,2'b00,0,0,0); endtask
  task automatic decode();       step(0,0,0,1,0,2'b00,0,0,0); endtask
  task automatic load_a();       step(0,0,0,0,0,2'b10,1,0,0); endtask
  task automatic zero_a();       step(0,0,0,0,0,2'b11,1,0,0); endtask
  task automatic input_a(input logic [W-1:0] v);
    Input = v;
    step(0,0,0,0,0,2'b01,1,0,0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_A", A_out, 8'h00);
    check("rst_PC", PC_out, 5'h00);
    check("rst_ir", ir, 3'b000);
    check("rst_Aeq0", Aeq0, 1'b1);
    check("rst_Apos", Apos, 1'b0);
    check("rst_halted", halted, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    prog(5'd0,  8'h0A);  // LOAD 10
    prog(5'd1,  8'h4B);  // ADD 11
    prog(5'd2,  8'h2C);  // STORE 12
    prog(5'd3,  8'h0C);  // LOAD 12
    prog(5'd4,  8'h6D);  // SUB 13
    prog(5'd5,  8'hBF);  // JZ 31
    prog(5'd10, 8'h05);
    prog(5'd11, 8'h03);
    prog(5'd13, 8'h05);
    prog(5'd31, 8'hDF);  // JPOS 31

    // LOAD 10
    idle(); fetch();
    check("load_ir", ir, 3'b000);
    check("load_pc", PC_out, 5'd1);
    decode(); load_a();
    check("load_A", A_out, 8'h05);
    check("load_Apos", Apos, 1'b1);
    check("load_Aeq0", Aeq0, 1'b0);

    // ADD 11
    idle(); fetch();
    check("add_ir", ir, 3'b010);
    decode(); step(0,0,0,0,0,2'b00,1,0,0);
    check("add_A", A_out, 8'h08);

    // STORE 12, clear A, then LOAD 12 to read it back
    idle(); fetch();
    check("store_ir", ir, 3'b001);
    step(0,0,0,1,1,2'b00,0,0,0);
    zero_a();
    check("zero_Aeq0", Aeq0, 1'b1);
    idle(); fetch(); decode(); load_a();
    check("store_readback", A_out, 8'h08);
    check("pc_after_4", PC_out, 5'd4);

    // SUB 13 with A = 3 wraps to 0xFE
    input_a(8'h03);
    idle(); fetch();
    check("sub_ir", ir, 3'b011);
    decode(); step(0,0,0,0,0,2'b00,1,1,0);
    check("sub_A", A_out, 8'hFE);
    check("sub_Aeq0", Aeq0, 1'b0);
    check("sub_Apos", Apos, 1'b0);
    zero_a();
    check("asel11_A", A_out, 8'h00);
    check("asel11_Aeq0", Aeq0, 1'b1);

    // JZ 31 taken, then PC wraps 0x1F -> 0x00
    idle(); fetch();
    check("jz_ir", ir, 3'b101);
    check("jz_pc_pre", PC_out, 5'd6);
    step(0,1,Aeq0,0,0,2'b00,0,0,0);
    check("jz_pc", PC_out, 5'h1F);
    idle(); fetch();
    check("wrap_pc", PC_out, 5'h00);
    check("jpos_ir", ir, 3'b110);

    // JPOS with A = 0x80 not taken
    input_a(8'h80);
    check("neg_Apos", Apos, 1'b0);
    step(0,1,Apos,0,0,2'b00,0,0,0);
    check("jpos_pc", PC_out, 5'h00);

    // INPUT
    input_a(8'h7F);
    check("in_A", A_out, 8'h7F);
    check("in_Apos", Apos, 1'b1);

    // Halt is sticky and does not freeze the datapath
    step(0,0,0,0,0,2'b00,0,0,1);
    check("halt_set", halted, 1'b1);
    repeat (10) idle();
    check("halt_sticky", halted, 1'b1);

    // prog_we and MemWr together: mem[10] gets prog_data, mem[PC=0] untouched
    prog_we = 1'b1; prog_addr = 5'd10; prog_data = 8'h33;
    step(0,0,0,0,1,2'b00,0,0,0);
    prog_we = 1'b0;
    idle(); fetch();
    check("coll_mem0", ir, 3'b000);
    decode(); load_a();
    check("coll_mem10", A_out, 8'h33);

    // Asynchronous reset mid-run with A = 0x55, PC = 3
    input_a(8'h55);
    fetch(); fetch();
    check("pre_rst_A", A_out, 8'h55);
    check("pre_rst_PC", PC_out, 5'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_A", A_out, 8'h00);
    check("mid_rst_PC", PC_out, 5'h00);
    check("mid_rst_ir", ir, 3'b000);
    check("mid_rst_Aeq0", Aeq0, 1'b1);
    check("mid_rst_Apos", Apos, 1'b0);
    check("mid_rst_halted", halted, 1'b0);
    #1 reset = 1'b0;
    idle(); fetch();
    check("ram_kept_ir", ir, 3'b000);
    decode(); load_a();
    check("ram_kept_A", A_out, 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
